// File: rtl/audio_codec_streamer.sv
// audio_codec_streamer: samples the mixer output once every DIV_CYCLES clocks,
// applies gain with saturation (or mute), queues the result in a small FIFO
// and hands it to the codec controller over its write/allowed handshake.
// Optional build macro: AUDIO_STREAMER_STEREO_PAN_EN adds a 2-bit pan input
// that routes the popped sample to the left/right channels.
module audio_codec_streamer #(
   parameter int unsigned DIV_CYCLES = 1042,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned GAIN_SHIFT = 0
) (
   input  logic                          CLOCK_50,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [31:0]                   channel_audio_in,
   input  logic                          mute,
   input  logic                          clear_status,
   input  logic                          audio_out_allowed,
`ifdef AUDIO_STREAMER_STEREO_PAN_EN
   input  logic [1:0]                    pan,
`endif
   output logic                          write_audio_out,
   output logic [31:0]                   left_channel_audio_out,
   output logic [31:0]                   right_channel_audio_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   overflow_count,
   output logic                          underrun
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   state_t             state;
   logic               primed;
   logic [15:0]        sample_cnt;
   logic               tick;
   logic signed [39:0] s_ext;
   logic signed [39:0] s_shift;
   logic [31:0]        s_sat;
   logic [31:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [31:0]        head;
   logic               full, empty, push, pop, drop, und_set;
   logic [31:0]        pan_l, pan_r;

   assign tick    = enable && (sample_cnt == 16'(DIV_CYCLES - 1));
   assign full    = (fifo_level == LW'(FIFO_DEPTH));
   assign empty   = (fifo_level == '0);
   assign pop     = enable && (state == IDLE) && !empty;
   // a full FIFO still accepts the tick sample when the head leaves on the same edge
   assign push    = tick && (!full || pop);
   assign drop    = tick && !push;
   assign und_set = (state == IDLE) && empty && audio_out_allowed && primed;
   assign head    = mem[rd_ptr];

   // the strobe is dropped the moment enable falls, so an abandoned write never fires
   assign write_audio_out = enable && (state == WRITE) && audio_out_allowed;

   // gain and saturation in a 40-bit signed intermediate
   always_comb begin
      s_ext   = mute ? 40'sd0 : {{8{channel_audio_in[31]}}, channel_audio_in};
      s_shift = s_ext <<< GAIN_SHIFT;
      if (s_shift > 40'sh007FFFFFFF)
         s_sat = 32'h7FFFFFFF;
      else if (s_shift < -40'sh0080000000)
         s_sat = 32'h80000000;
      else
         s_sat = s_shift[31:0];
   end

   // channel routing of the head sample at pop time
   always_comb begin
      pan_l = head;
      pan_r = head;
`ifdef AUDIO_STREAMER_STEREO_PAN_EN
      case (pan)
         2'b01:   pan_r = '0;
         2'b10:   pan_l = '0;
         2'b11: begin
            pan_l = {head[31], head[31:1]};
            pan_r = {head[31], head[31:1]};
         end
         default: ;
      endcase
`endif
   end

   // sample-rate divider, restarts from zero whenever streaming is disabled
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)
         sample_cnt <= '0;
      else if (!enable || tick)
         sample_cnt <= '0;
      else
         sample_cnt <= sample_cnt + 16'd1;
   end

   // FIFO storage, no reset needed since level gates every read
   always_ff @(posedge CLOCK_50) begin
      if (push)
         mem[wr_ptr] <= s_sat;
   end

   // FIFO pointers and occupancy; disable flushes everything
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (!enable) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: ;
         endcase
      end
   end

   // handshake FSM: load a sample in IDLE, hold it in WRITE until accepted
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state                   <= IDLE;
         primed                  <= 1'b0;
         left_channel_audio_out  <= '0;
         right_channel_audio_out <= '0;
      end else if (!enable) begin
         state  <= IDLE;
         primed <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!empty) begin
               left_channel_audio_out  <= pan_l;
               right_channel_audio_out <= pan_r;
               primed                  <= 1'b1;
               state                   <= WRITE;
            end
            WRITE: if (audio_out_allowed) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // sticky status; clear_status beats a same-edge increment or set
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         overflow_count <= '0;
         underrun       <= 1'b0;
      end else if (clear_status) begin
         overflow_count <= '0;
         underrun       <= 1'b0;
      end else begin
         if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
         if (und_set) underrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_codec_streamer.sv
// Randomized bench for audio_codec_streamer with a queue-based reference model
// and a per-cycle scoreboard checked on the falling edge.
module tb_audio_codec_streamer;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
   localparam int GS    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0, mute = 1'b0, clr = 1'b0, allowed = 1'b0;
   logic [31:0]   ain = '0;
`ifdef AUDIO_STREAMER_STEREO_PAN_EN
   logic [1:0]    pan = '0;
`endif
   logic          wr;
   logic [31:0]   lch, rch;
   logic [LW-1:0] lvl;
   logic [15:0]   ovf_cnt;
   logic          und_flag;

   always #5 clk = ~clk;

   audio_codec_streamer #(.DIV_CYCLES(DIV), .FIFO_DEPTH(DEPTH), .GAIN_SHIFT(GS)) dut (
      .CLOCK_50(clk), .reset_n(rst_n), .enable(en), .channel_audio_in(ain),
      .mute(mute), .clear_status(clr), .audio_out_allowed(allowed),
`ifdef AUDIO_STREAMER_STEREO_PAN_EN
      .pan(pan),
`endif
      .write_audio_out(wr), .left_channel_audio_out(lch),
      .right_channel_audio_out(rch), .fifo_level(lvl),
      .overflow_count(ovf_cnt), .underrun(und_flag));

   typedef struct {
      logic        wr;
      logic [31:0] l, r;
      int          lvl, ovf;
      logic        und;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0, fails = 0;

   // reference model state: transaction-level view of the streamer
   int          m_cnt;
   logic [31:0] m_fq[$];
   bit          m_hv;
   logic [31:0] m_hl, m_hr;
   bit          m_primed;
   int          m_ovf;
   bit          m_und;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] proc(logic [31:0] a, logic m);
      longint v;
      v = m ? 64'sd0 : longint'($signed(a));
      v = v * (longint'(1) << GS);
      if (v > 64'sd2147483647)  v = 64'sd2147483647;
      if (v < -64'sd2147483648) v = -64'sd2147483648;
      return v[31:0];
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_fq.delete(); m_hv = 0; m_hl = '0; m_hr = '0;
      m_primed = 0; m_ovf = 0; m_und = 0;
   endtask

   // advance the model across one rising edge using the pre-edge inputs
   task automatic model_edge();
      bit          u_set, tk;
      logic [31:0] v;
      if (!rst_n) begin
         model_reset();
         return;
      end
      u_set = !m_hv && m_fq.size() == 0 && allowed && m_primed;
      if (!en) begin
         m_cnt = 0; m_fq.delete(); m_hv = 0; m_primed = 0;
      end else begin
         tk = (m_cnt == DIV - 1);
         m_cnt = tk ? 0 : m_cnt + 1;
         if (m_hv) begin
            if (allowed) m_hv = 0;
         end else if (m_fq.size() > 0) begin
            v = m_fq.pop_front();
            m_hv = 1; m_primed = 1; m_hl = v; m_hr = v;
`ifdef AUDIO_STREAMER_STEREO_PAN_EN
            case (pan)
               2'b01: m_hr = '0;
               2'b10: m_hl = '0;
               2'b11: begin m_hl = $signed(v) >>> 1; m_hr = $signed(v) >>> 1; end
               default: ;
            endcase
`endif
         end
         if (tk) begin
            if (m_fq.size() < DEPTH) m_fq.push_back(proc(ain, mute));
            else if (m_ovf < 65535) m_ovf++;
         end
      end
      if (u_set) m_und = 1;
      if (clr) begin m_ovf = 0; m_und = 0; end
   endtask

   task automatic push_expect();
      exp_t e;
      e.wr  = rst_n && en && m_hv && allowed;
      e.l   = m_hl;
      e.r   = m_hr;
      e.lvl = m_fq.size();
      e.ovf = m_ovf;
      e.und = m_und;
      exp_q.push_back(e);
   endtask

   // monitor: one expected record per cycle, compared mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("write_audio_out", 32'(wr), 32'(e.wr));
         check("left", lch, e.l);
         check("right", rch, e.r);
         check("fifo_level", 32'(lvl), 32'(e.lvl));
         check("overflow_count", 32'(ovf_cnt), 32'(e.ovf));
         check("underrun", 32'(und_flag), 32'(e.und));
      end
   end

   // phase table: enable %, allowed %, mute %, clear %
   int ph_en[8]  = '{100, 100, 100, 85, 100, 95, 100, 70};
   int ph_al[8]  = '{100,   0,   0, 50,  30, 70, 100, 20};
   int ph_mu[8]  = '{  0,   0,   0, 20,   0, 10,  50,  0};
   int ph_cl[8]  = '{  0,   0,   5,  5,   0,  3,  10,  2};

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0: return 32'h10000000;
         1: return 32'hF0000000;
         2: return 32'h07FFFFFF;
         3: return 32'hF8000000;
         4: return 32'h00001234;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      bit rst_done = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_write", 32'(wr), 32'd0);
      check("reset_level", 32'(lvl), 32'd0);
      check("reset_left", lch, 32'd0);
      check("reset_overflow", 32'(ovf_cnt), 32'd0);
      check("reset_underrun", 32'(und_flag), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int p = 0; p < 8; p++) begin
         for (int c = 0; c < 150; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            if (!rst_n) rst_n = 1'b1;
            en      = ($urandom_range(0, 99) < ph_en[p]);
            allowed = ($urandom_range(0, 99) < ph_al[p]);
            mute    = ($urandom_range(0, 99) < ph_mu[p]);
            clr     = ($urandom_range(0, 99) < ph_cl[p]);
            ain     = pick_val();
`ifdef AUDIO_STREAMER_STEREO_PAN_EN
            pan     = 2'($urandom_range(0, 3));
`endif
            // asynchronous reset in the middle of a pending write
            if (p == 5 && c > 20 && !rst_done && m_hv && en) begin
               rst_done = 1;
               allowed  = 1'b1;
               #1;
               check("pre_reset_write", 32'(wr), 32'd1);
               rst_n = 1'b0;
               #1;
               check("async_reset_write", 32'(wr), 32'd0);
               check("async_reset_level", 32'(lvl), 32'd0);
               model_reset();
            end
            push_expect();
         end
      end
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("async_reset_exercised", 32'(rst_done), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
